// File: rtl/cardinal_nic.sv
// -----------------------------------------------------------------------------
// cardinal_nic -- single-entry network interface between a CPU register port
// and a router link.
//
// One 64-bit input buffer (router -> CPU) and one 64-bit output buffer
// (CPU -> router), each with a full flag. The CPU sees four registers:
//   addr 00 in-buf     (read pops the input buffer)
//   addr 01 in-status  (in_full in bit 63)
//   addr 10 out-buf    (write loads the output buffer when it is empty)
//   addr 11 out-status (out_full in bit 63)
// A packet is offered to the router only when its bit 0 matches the router's
// current virtual-channel phase (net_polarity).
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   addr[0:1]      register select
//   d_in[0:63]     CPU write data
//   d_out[0:63]    registered CPU read data (one-cycle latency)
//   nicEn          CPU access strobe
//   nicWrEn        1 = write, 0 = read (qualified by nicEn)
//   net_si         packet valid toward router
//   net_ri         router ready
//   net_di[0:63]   packet toward router
//   net_so         packet valid from router
//   net_ro         NIC ready for a packet
//   net_do[0:63]   packet from router
//   net_polarity   router virtual-channel phase
//
// Configuration macro: CARDINAL_NIC_PKT_CNT_EN
//   When defined, 16-bit wrapping received/sent packet counters appear in
//   bits 32:47 of the in-status / out-status reads. When undefined there are
//   no counters and status bits 0:62 read as zero.
//
// All vectors use [0:N] numbering: bit 0 is the most significant bit.
// -----------------------------------------------------------------------------
module cardinal_nic (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:1]  addr,
  input  logic [0:63] d_in,
  output logic [0:63] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  output logic        net_si,
  input  logic        net_ri,
  output logic [0:63] net_di,
  input  logic        net_so,
  output logic        net_ro,
  input  logic [0:63] net_do,
  input  logic        net_polarity
);

  localparam logic [0:1] ADDR_IN_BUF  = 2'b00;
  localparam logic [0:1] ADDR_IN_STS  = 2'b01;
  localparam logic [0:1] ADDR_OUT_BUF = 2'b10;
  localparam logic [0:1] ADDR_OUT_STS = 2'b11;

  logic [0:63] in_buf;
  logic [0:63] out_buf;
  logic        in_full;
  logic        out_full;

  logic        cpu_rd;
  logic        cpu_wr;
  logic        rx_capture;
  logic        rx_pop;
  logic        tx_load;

  logic [0:63] in_status;
  logic [0:63] out_status;
  logic [0:63] rd_data;

  // ---------------------------------------------------------------------------
  // Router-side handshakes and CPU decode
  // ---------------------------------------------------------------------------
  assign net_ro = ~in_full;
  assign net_di = out_buf;
  assign net_si = out_full & net_ri & (out_buf[0] == net_polarity);

  assign cpu_rd = nicEn & ~nicWrEn;
  assign cpu_wr = nicEn &  nicWrEn;

  // A packet arriving while the buffer is full is simply not taken; the
  // router sees net_ro low and must hold it.
  assign rx_capture = net_so & ~in_full;
  assign rx_pop     = cpu_rd & (addr == ADDR_IN_BUF) & in_full;

  // A write in the cycle the buffer drains is dropped: out_full is still set
  // from the CPU's point of view until that edge.
  assign tx_load = cpu_wr & (addr == ADDR_OUT_BUF) & ~out_full;

`ifdef CARDINAL_NIC_PKT_CNT_EN
  logic [15:0] rx_cnt;
  logic [15:0] tx_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt <= 16'h0000;
      tx_cnt <= 16'h0000;
    end else begin
      // Natural 16-bit overflow gives the FFFF -> 0000 wrap.
      if (rx_capture) rx_cnt <= rx_cnt + 16'h0001;
      if (net_si)     tx_cnt <= tx_cnt + 16'h0001;
    end
  end

  assign in_status  = {32'b0, rx_cnt, 15'b0, in_full};
  assign out_status = {32'b0, tx_cnt, 15'b0, out_full};
`else
  assign in_status  = {63'b0, in_full};
  assign out_status = {63'b0, out_full};
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    rd_data = 64'b0;
    unique case (addr)
      ADDR_IN_BUF:  rd_data = in_buf;
      ADDR_IN_STS:  rd_data = in_status;
      ADDR_OUT_BUF: rd_data = out_buf;
      ADDR_OUT_STS: rd_data = out_status;
      default:      rd_data = 64'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Buffers are cleared as well as the flags so nothing stale can be
      // read back or emitted after a mid-operation reset.
      in_buf   <= 64'b0;
      out_buf  <= 64'b0;
      in_full  <= 1'b0;
      out_full <= 1'b0;
      d_out    <= 64'b0;
    end else begin
      // NOTE: non-blocking assignments here so every read below sees the
      // pre-edge value of in_full/out_full, regardless of statement order.
      if (cpu_rd) d_out <= rd_data;

      // Capture and pop are mutually exclusive: capture needs in_full=0,
      // pop needs in_full=1. A packet offered in the pop cycle is refused.
      if (rx_capture) begin
        in_buf  <= net_do;
        in_full <= 1'b1;
      end else if (rx_pop) begin
        in_full <= 1'b0;
      end

      if (net_si) begin
        out_full <= 1'b0;
      end else if (tx_load) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cardinal_nic.md
CARDINAL_NIC -- requirements
Module: cardinal_nic

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have port addr, input, 2 [0:1], register select from the CPU data port: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status.
REQ-004 SHALL have port d_in, input, 64 [0:63], CPU write data.
REQ-005 SHALL have port d_out, output, 64 [0:63], registered CPU read data.
REQ-006 SHALL have port nicEn, input, 1, CPU access strobe.
REQ-007 SHALL have port nicWrEn, input, 1, 1 = write, 0 = read; qualified by nicEn.
REQ-008 SHALL have port net_si, output, 1, packet valid toward the router.
REQ-009 SHALL have port net_ri, input, 1, router ready to accept a packet.
REQ-010 SHALL have port net_di, output, 64 [0:63], packet toward the router.
REQ-011 SHALL have port net_so, input, 1, packet valid from the router.
REQ-012 SHALL have port net_ro, output, 1, NIC ready to accept a packet.
REQ-013 SHALL have port net_do, input, 64 [0:63], packet from the router.
REQ-014 SHALL have port net_polarity, input, 1, current router virtual-channel phase.

Function
REQ-015 SHALL hold one 64-bit input buffer with flag in_full and one 64-bit output buffer with flag out_full.
REQ-016 SHALL drive net_ro = ~in_full combinationally.
REQ-017 SHALL, when net_so=1 and in_full=0, capture net_do into the input buffer and set in_full at that edge; net_so while in_full=1 SHALL be ignored.
REQ-018 SHALL, on read (nicEn=1, nicWrEn=0), load d_out at that edge: addr 00 -> in-buf, 01 -> {63'b0, in_full}, 10 -> out-buf, 11 -> {63'b0, out_full}; one-cycle read latency.
REQ-019 SHALL clear in_full at the edge of a read of addr 00 if in_full=1; reading addr 00 while empty returns the stale buffer and changes no state.
REQ-020 SHALL, when a read of addr 00 and net_so occur in the same cycle with in_full=1, clear in_full and drop net_so (net_ro was low).
REQ-021 SHALL, on write (nicEn=1, nicWrEn=1) to addr 10 with out_full=0, load d_in and set out_full; a write while out_full=1 SHALL be dropped with no state change.
REQ-022 SHALL ignore writes to addr 00, 01 and 11.
REQ-023 SHALL drive net_di = out-buf and net_si = out_full & net_ri & (out-buf bit 0 == net_polarity), combinationally.
REQ-024 SHALL clear out_full at the edge where net_si=1; a CPU write in that same cycle SHALL be dropped (no same-cycle drain and refill).
REQ-025 SHALL hold d_out unchanged in cycles without a read.

Reset
REQ-026 SHALL, while reset=0, asynchronously clear in_full, out_full, both buffers, d_out and all counters to 0.
REQ-027 SHALL therefore drive net_ro=1 and net_si=0 during reset.
REQ-028 SHALL discard any buffered packet when reset asserts mid-operation; no packet is emitted after release until a new CPU write.

Configuration
REQ-029 SHALL, with CARDINAL_NIC_PKT_CNT_EN defined, keep 16-bit wrapping counters of packets received (REQ-017 captures) and sent (net_si=1 edges), returned in bits 32:47 of status reads at addr 01 and 11 respectively; 16'hFFFF increments to 16'h0000.
REQ-030 SHALL, without CARDINAL_NIC_PKT_CNT_EN, contain no counters, with status bits 0:62 reading 0.

Verification
REQ-031 Reset: reset=0 then 1 -> net_ro=1, net_si=0, d_out=0; read addr 01 and 11 -> d_out=0 one cycle later.
REQ-032 Receive: net_so=1, net_do=64'hA5A5_0000_0000_0001 -> net_ro=0 next cycle; read 01 -> bit 63=1; read 00 -> d_out=64'hA5A5_0000_0000_0001 and net_ro=1 the next cycle.
REQ-033 Send polarity: write addr 10 d_in=64'h8000_0000_0000_00FF (bit0=1), net_ri=1, net_polarity=0 -> net_si=0; polarity=1 -> net_si=1, net_di=that value, out_full=0 next cycle.
REQ-034 Overflow: two writes to addr 10 (values 1 then 2) with net_ri=0 -> out-buf reads 1; second net_so while in_full=1 -> input buffer keeps first packet.
REQ-035 Simultaneous: read 00 and net_so=1 with in_full=1 -> in_full=0 after edge, new packet not captured; write 10 in the net_si=1 cycle -> dropped, out_full=0.
REQ-036 With CARDINAL_NIC_PKT_CNT_EN: 3 receives -> read 01 bits 32:47=16'h0003; preset by 65536 sends -> sent count wraps to 16'h0000.
